// File: rtl/spi_ram_pkg.sv
// spi_ram_pkg: opcode encoding, arm-state encoding and width helper for spi_ram_ctrl
package spi_ram_pkg;

    typedef enum logic [1:0] {
        OP_WR_ADDR = 2'b00,
        OP_WR_DATA = 2'b01,
        OP_RD_ADDR = 2'b10,
        OP_RD_DATA = 2'b11
    } opcode_e;

    localparam logic [0:0] ST_IDLE  = 1'b0;
    localparam logic [0:0] ST_ARMED = 1'b1;

    function automatic int max_w(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/sp_ram.sv
// sp_ram: single-port synchronous RAM with a read-enabled registered output
module sp_ram #(
    parameter int ADDR_W    = 8,
    parameter int DATA_W    = 8,
    parameter int MEM_DEPTH = 256
) (
    input  logic              clk,
    input  logic              i_we,
    input  logic              i_re,
    input  logic [ADDR_W-1:0] i_addr,
    input  logic [DATA_W-1:0] i_wdata,
    output logic [DATA_W-1:0] o_rdata
);

    logic [DATA_W-1:0] r_mem [MEM_DEPTH];
    logic [DATA_W-1:0] r_rdata;

    // rdata only moves on a read so the last read word stays presented
    always_ff @(posedge clk) begin
        if (i_we) r_mem[i_addr] <= i_wdata;
        if (i_re) r_rdata <= r_mem[i_addr];
    end

    assign o_rdata = r_rdata;

endmodule

// File: rtl/spi_ram_ctrl.sv
// spi_ram_ctrl: frame-decoding RAM controller with independent write/read pointers behind an SPI slave
module spi_ram_ctrl
    import spi_ram_pkg::*;
#(
    parameter int ADDR_W    = 8,
    parameter int DATA_W    = 8,
    parameter int MEM_DEPTH = 256,
    parameter bit AUTO_INC  = 1'b1
) (
    input  logic                               clk,
    input  logic                               rst_n,
    input  logic                               i_rx_valid,
    input  logic [max_w(ADDR_W, DATA_W)+1:0]   i_din,
    output logic [DATA_W-1:0]                  o_dout,
    output logic                               o_tx_valid,
    output logic                               o_err,
    output logic                               o_wr_armed,
    output logic                               o_rd_armed
);

    localparam int PAY_W = max_w(ADDR_W, DATA_W);
    localparam logic [ADDR_W-1:0] LAST = ADDR_W'(MEM_DEPTH - 1);

    opcode_e           w_op;
    logic [ADDR_W-1:0] w_addr;
    logic [ADDR_W-1:0] w_ram_addr;
    logic [DATA_W-1:0] w_wdata;
    logic [DATA_W-1:0] w_rdata;
    logic              w_in_range;
    logic              w_wr_set;
    logic              w_rd_set;
    logic              w_wr_data;
    logic              w_rd_data;
    logic              w_we;
    logic              w_re;
    logic              w_bad;

    logic [0:0]        r_wr_st;
    logic [0:0]        r_rd_st;
    logic [ADDR_W-1:0] r_wr_ptr;
    logic [ADDR_W-1:0] r_rd_ptr;
    logic              r_err;
    logic              r_tx;
    logic              r_rd_seen;

    function automatic logic [ADDR_W-1:0] nxt(input logic [ADDR_W-1:0] p);
        return (p == LAST) ? '0 : p + ADDR_W'(1);
    endfunction

    assign w_op       = opcode_e'(i_din[PAY_W+1:PAY_W]);
    assign w_addr     = i_din[ADDR_W-1:0];
    assign w_wdata    = i_din[DATA_W-1:0];
    assign w_in_range = int'(w_addr) < MEM_DEPTH;

    assign w_wr_set  = i_rx_valid && w_op == OP_WR_ADDR && w_in_range;
    assign w_rd_set  = i_rx_valid && w_op == OP_RD_ADDR && w_in_range;
    assign w_wr_data = i_rx_valid && w_op == OP_WR_DATA;
    assign w_rd_data = i_rx_valid && w_op == OP_RD_DATA;
    assign w_we      = w_wr_data && r_wr_st == ST_ARMED;
    assign w_re      = w_rd_data && r_rd_st == ST_ARMED;

    // out-of-range address frames and data frames on an idle side are rejected
    assign w_bad = (i_rx_valid && (w_op == OP_WR_ADDR || w_op == OP_RD_ADDR) && !w_in_range)
                 || (w_wr_data && !w_we) || (w_rd_data && !w_re);

    assign w_ram_addr = w_wr_data ? r_wr_ptr : r_rd_ptr;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_st   <= ST_IDLE;
            r_rd_st   <= ST_IDLE;
            r_wr_ptr  <= '0;
            r_rd_ptr  <= '0;
            r_err     <= 1'b0;
            r_tx      <= 1'b0;
            r_rd_seen <= 1'b0;
        end else begin
            r_err     <= w_bad;
            r_tx      <= w_re;
            r_rd_seen <= r_rd_seen | w_re;
            r_wr_ptr  <= w_wr_set ? w_addr : (w_we && AUTO_INC) ? nxt(r_wr_ptr) : r_wr_ptr;
            r_rd_ptr  <= w_rd_set ? w_addr : (w_re && AUTO_INC) ? nxt(r_rd_ptr) : r_rd_ptr;
            r_wr_st   <= w_wr_set ? ST_ARMED : (w_we && !AUTO_INC) ? ST_IDLE : r_wr_st;
            r_rd_st   <= w_rd_set ? ST_ARMED : (w_re && !AUTO_INC) ? ST_IDLE : r_rd_st;
        end
    end

    sp_ram #(
        .ADDR_W   (ADDR_W),
        .DATA_W   (DATA_W),
        .MEM_DEPTH(MEM_DEPTH)
    ) u_ram (
        .clk    (clk),
        .i_we   (w_we),
        .i_re   (w_re),
        .i_addr (w_ram_addr),
        .i_wdata(w_wdata),
        .o_rdata(w_rdata)
    );

    // the RAM output register has no reset, so dout reads 0 until the first read lands
    assign o_dout     = r_rd_seen ? w_rdata : '0;
    assign o_tx_valid = r_tx;
    assign o_err      = r_err;
    assign o_wr_armed = r_wr_st == ST_ARMED;
    assign o_rd_armed = r_rd_st == ST_ARMED;

endmodule
